// File: rtl/pipeline_hazard_controller.sv
// Stall/flush/forwarding controller for the 5-stage core, with memory-wait FSM and timeout error.
// Optional performance counters are enabled with the HAZARD_PERF_CNT_EN macro.
module pipeline_hazard_controller #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [1:0] ResultSrcE,
  input  logic [1:0] PCSrcE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemReqM,
  input  logic       MemReadyM,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushW,
  output logic       MemErr,
  output logic       MemBusy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] StallCnt,
  output logic [31:0] FlushCnt,
  output logic [31:0] MemWaitCnt
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;
  logic             lw_stall;
  logic             redir;
  logic             mem_stall;

  // M-stage result is younger than W, so it wins when both match.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic wm, input logic [4:0] rdm,
                                         input logic ww, input logic [4:0] rdw);
    if (wm && rdm != 5'd0 && rdm == rs)
      return 2'b10;
    else if (ww && rdw != 5'd0 && rdw == rs)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign lw_stall  = (ResultSrcE == 2'b01) && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign redir     = (PCSrcE != 2'b00);
  assign mem_stall = (state == WAIT) || (state == ERR) || (state == IDLE && MemReqM && !MemReadyM);
  assign MemBusy   = (state == WAIT);
  assign MemErr    = err_q;

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    if (!rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else begin
      ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
      ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
      // A frozen pipeline defers redirect and load-use; their inputs stay held.
      if (mem_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (redir) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (lw_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (MemReqM && !MemReadyM) begin
            state    <= WAIT;
            wait_cnt <= CNT_W'(1);
          end
        end
        WAIT: begin
          if (MemReadyM) begin
            state    <= IDLE;
            wait_cnt <= '0;
          end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES)) begin
            state <= ERR;
            err_q <= 1'b1;
          end else if (wait_cnt != {CNT_W{1'b1}}) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ERR: begin
          err_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic any_stall;
  logic redir_flush;
  assign any_stall   = StallF | StallD | StallE | StallM;
  assign redir_flush = rst && !mem_stall && redir;

  always_ff @(posedge clk) begin
    if (!rst) begin
      StallCnt   <= '0;
      FlushCnt   <= '0;
      MemWaitCnt <= '0;
    end else begin
      if (any_stall && StallCnt != 32'hFFFF_FFFF)
        StallCnt <= StallCnt + 32'd1;
      if (redir_flush && FlushCnt != 32'hFFFF_FFFF)
        FlushCnt <= FlushCnt + 32'd1;
      if (MemBusy && MemWaitCnt != 32'hFFFF_FFFF)
        MemWaitCnt <= MemWaitCnt + 32'd1;
    end
  end
`endif

endmodule
